// File: rtl/div_unit_pkg.sv
// Shared state encodings, iteration count and operand helper for the
// iterative divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_RUN   = 2'd1,
    DIV_FIXUP = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_e;

  localparam int DIV_ITERS = 32;

  // Magnitude of an operand: the absolute value for signed, the raw value for unsigned.
  function automatic logic [31:0] div_mag(input logic [31:0] v, input logic is_sgn);
    return (is_sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step: shift {rem, quo} left by one, then subtract
// the divisor magnitude when it fits.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dmag_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;
  logic             unused_bits;

  // The shifted remainder can need WIDTH+1 bits; the extra top bit of trial
  // is the borrow that decides the quotient bit.
  assign shifted     = {rem_i, quo_i[WIDTH-1]};
  assign trial       = {1'b0, shifted} - {2'b00, dmag_i};
  assign fits        = ~trial[WIDTH+1];
  assign unused_bits = ^{trial[WIDTH], shifted[WIDTH]};

  always_comb begin
    quo_o = {quo_i[WIDTH-2:0], fits};
    rem_o = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit DIV/DIVU unit: hi = remainder, lo = quotient, written back
// through a one-cycle has_div_w pulse.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = DIV_ITERS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             has_div_w,
  output logic [WIDTH-1:0] reg_hi_w,
  output logic [WIDTH-1:0] reg_lo_w
);

  localparam int CW = $clog2(ITERS);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dmag_i (dmag_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dmag_q  <= dmag_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dmag_d  = dmag_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      DIV_IDLE: begin
        if (start && !cancel) begin
          negq_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d = is_signed & dividend[WIDTH-1];
          if (divisor == '0) begin
            hi_d    = dividend;
            lo_d    = '1;
            state_d = DIV_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = div_mag(dividend, is_signed);
            dmag_d  = div_mag(divisor, is_signed);
            cnt_d   = '0;
            state_d = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1)) state_d = DIV_FIXUP;
      end
      DIV_FIXUP: begin
        // negq/negr are only ever set for signed operations.
        lo_d    = negq_q ? ('0 - quo_q) : quo_q;
        hi_d    = negr_q ? ('0 - rem_q) : rem_q;
        state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (cancel && state_q != DIV_IDLE) begin
      state_d = DIV_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  assign busy      = (state_q != DIV_IDLE);
  assign has_div_w = (state_q == DIV_DONE) && !cancel;
  assign reg_hi_w  = hi_q;
  assign reg_lo_w  = lo_q;

endmodule
